bus_mem_model: RTL and testbench
================================

Name: bus_mem_model

Overview:
- Parametrised Avalon-style slave memory model for CPU bus testbenches, plus the fixed 0-wait RAM model's successor.
- Adds a configurable base address and depth.
- Adds fixed or pseudo-random wait-state insertion, protocol/address error detection, and transfer counters.
- Sits between the CPU's bus master port and the testbench; the CPU sees the real waitrequest back-pressure.

Parameters:
- RAM_INIT_FILE, "", hex file loaded with $readmemh at time 0; empty string means memory is zero-filled.
- BASE_ADDR, 32'hBFC00000, byte address of word 0.
- DEPTH_WORDS, 16384, number of 32-bit words.
- WAIT_MODE, 0, 0 = fixed wait states; 1 = pseudo-random wait states.
- WAIT_CYCLES, 0, fixed stall count in mode 0; maximum stall count in mode 1 (0..15).
- LFSR_SEED, 8'hA5, reset value of the LFSR; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- address  in  32  byte address from master.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  4  byte lane enables; bit i maps to writedata[8i+7:8i].
- writedata  in  32  write data.
- waitrequest  out  1  high = transfer not accepted this cycle.
- readdata  out  32  read data, valid when read && !waitrequest.
- err  out  1  sticky protocol/address error flag.
- rd_count  out  32  completed reads.
- wr_count  out  32  completed writes.
- stall_count  out  32  total cycles with waitrequest high.

Behaviour:
- Reset (rst_n low at clk edge):
  - FSM goes to IDLE; err, rd_count, wr_count and stall_count go to 0; LFSR loads LFSR_SEED.
  - Memory contents are not reset.
  - Reset mid-transfer abandons it; no write is performed.
- Address decode:
  - idx = (address - BASE_ADDR) >> 2.
  - In range iff address >= BASE_ADDR, idx < DEPTH_WORDS, and address[1:0] == 0.
- Request: req = read ^ write. read && write together is illegal:
  - err is set; nothing is written; waitrequest = 0; readdata = 0.
  - The FSM stays IDLE.
- Stall count N per transfer, fixed at the cycle the request is first seen in IDLE:
  - Mode 0: N = WAIT_CYCLES.
  - Mode 1: N = lfsr[3:0] % (WAIT_CYCLES+1).
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances once per accepted request, on the completion edge.
- FSM IDLE / STALL / ACK:
  - IDLE, !req: waitrequest = 0.
  - IDLE, req, N == 0: waitrequest = 0; the transfer completes at this edge; stay IDLE.
  - IDLE, req, N > 0: waitrequest = 1; load counter with N-1. Go to ACK if N == 1, else to STALL.
  - STALL: waitrequest = 1; decrement the counter; go to ACK when the counter reaches 1 before the decrement.
  - ACK: waitrequest = 0; the transfer completes at this edge; go to IDLE.
  - Net timing: a request held from cycle 0 sees exactly N cycles of waitrequest = 1 and completes in cycle N.
- Master drops the request, or changes address or direction, while in STALL/ACK:
  - This is a protocol violation; err is set and the FSM returns to IDLE.
  - Nothing is written and no counter increments.
- Write completion:
  - If in range, for each i with byteenable[i] = 1, mem[idx] byte i is updated at the edge.
  - byteenable = 0 completes with no change and still counts.
- Read completion:
  - readdata = mem[idx], combinational, while read && !waitrequest.
  - readdata is 0 in all other cycles.
- Out of range or misaligned:
  - The transfer completes normally with normal timing and is counted.
  - A read returns 32'hDEADBEEF; a write is dropped.
  - err is set.
- Counters:
  - rd_count / wr_count increment on the completion edge.
  - stall_count increments on every edge where waitrequest = 1.
  - All counters wrap modulo 2^32.
- err is cleared only by reset.

Test Plan:
- WAIT_CYCLES = 0, mode 0, file word0 = 32'h24020005:
  - read at BFC00000 -> waitrequest = 0 in the same cycle, readdata = 24020005, rd_count = 1.
- WAIT_CYCLES = 3, mode 0:
  - write BFC00010, data 11223344, be = 4'b0101, held until accepted -> waitrequest high for exactly 3 cycles, completes cycle 3.
  - Readback of the prior value AABBCCDD gives AA22CC44; stall_count = 6.
- Mode 1, WAIT_CYCLES = 7, seed A5:
  - 20 back-to-back reads -> each stall equals the reference-model LFSR value % 8; data correct; rd_count = 20.
- Read address 00000000, then BFC00002 -> both return DEADBEEF; err = 1 after the first; rd_count = 2.
- read && write together, and separately a read dropped during STALL -> err = 1, memory unchanged, counters unchanged, FSM IDLE next cycle.
- rst_n low for 1 cycle during STALL of a write -> target word unchanged; counters and err = 0.
  - The next read completes with a fresh N drawn from the reseeded LFSR.

Source files
------------

// File: rtl/bus_mem_model.sv
// rtl/bus_mem_model.sv - Avalon-style slave memory model with wait states, error flag and counters
module bus_mem_model #(
  parameter string       RAM_INIT_FILE = "",
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int          DEPTH_WORDS   = 16384,
  parameter int          WAIT_MODE     = 0,
  parameter int          WAIT_CYCLES   = 0,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] stall_count
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;
  localparam logic [3:0]  WC      = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        dir_q, dir_d;
  logic [7:0]  lfsr_q;
  logic        err_q;
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             in_range, req, both, broken, complete, set_err;
  logic [4:0]       n_mod;
  logic [3:0]       n_w;

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  end

  assign word_off = (address - BASE_ADDR) >> 2;
  assign idx      = word_off[IDX_W-1:0];
  assign in_range = (address >= BASE_ADDR) && (word_off < DEPTH_L) && (address[1:0] == 2'b00);
  assign req      = read ^ write;
  assign both     = read & write;
  assign broken   = !req || (address != addr_q) || (write != dir_q);
  assign n_mod    = {1'b0, lfsr_q[3:0]} % ({1'b0, WC} + 5'd1);
  assign n_w      = (WAIT_MODE == 0) ? WC : n_mod[3:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dir_d       = dir_q;
    waitrequest = 1'b0;
    complete    = 1'b0;
    set_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (both) begin
          set_err = 1'b1;
        end else if (req) begin
          addr_d = address;
          dir_d  = write;
          if (n_w == 4'd0) begin
            complete = 1'b1;
          end else begin
            waitrequest = 1'b1;
            cnt_d       = n_w - 4'd1;
            state_d     = (n_w == 4'd1) ? ACK : STALL;
          end
        end
      end
      STALL: begin
        waitrequest = 1'b1;
        if (broken) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (broken) set_err = 1'b1;
        else        complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (complete && !in_range) set_err = 1'b1;
  end

  always_comb begin
    readdata = '0;
    if (complete && read) readdata = in_range ? mem[idx] : 32'hDEADBEEF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      dir_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      err_q       <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      if (set_err)     err_q       <= 1'b1;
      if (waitrequest) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (complete) begin
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        if (write) wr_cnt_q <= wr_cnt_q + 32'd1;
        else       rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && complete && write && in_range) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  assign err         = err_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_bus_mem_model.sv
// tb/tb_bus_mem_model.sv - scoreboard bench for bus_mem_model: fixed 0/3 and random 7 wait configs
module tb_bus_mem_model;
  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n       [3];
  logic [31:0] address     [3];
  logic        read        [3];
  logic        write       [3];
  logic [3:0]  byteenable  [3];
  logic [31:0] writedata   [3];
  logic        waitrequest [3];
  logic [31:0] readdata    [3];
  logic        err         [3];
  logic [31:0] rd_count    [3];
  logic [31:0] wr_count    [3];
  logic [31:0] stall_count [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    bus_mem_model #(
      .RAM_INIT_FILE(""),
      .BASE_ADDR(BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_MODE((k == 2) ? 1 : 0),
      .WAIT_CYCLES((k == 0) ? 0 : ((k == 1) ? 3 : 7)),
      .LFSR_SEED(8'hA5)
    ) u_dut (
      .clk(clk), .rst_n(rst_n[k]), .address(address[k]), .read(read[k]), .write(write[k]),
      .byteenable(byteenable[k]), .writedata(writedata[k]), .waitrequest(waitrequest[k]),
      .readdata(readdata[k]), .err(err[k]), .rd_count(rd_count[k]), .wr_count(wr_count[k]),
      .stall_count(stall_count[k])
    );
  end

  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  lfsr_m [3];
  logic [31:0] mdl [3][DEPTH];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic int exp_n(input int k);
    if (k == 0) return 0;
    if (k == 1) return 3;
    return int'(lfsr_m[2][3:0]) % 8;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return (a >= BASE) && (off < DEPTH) && (a[1:0] == 2'b00);
  endfunction

  task automatic do_reset(input int k);
    @(negedge clk);
    rst_n[k] = 1'b0; read[k] = 1'b0; write[k] = 1'b0;
    @(negedge clk);
    rst_n[k] = 1'b1;
    lfsr_m[k] = 8'hA5;
  endtask

  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input string tag);
    int          n, stalls;
    logic [31:0] idx, w, e;
    n = exp_n(k);
    idx = (a - BASE) >> 2;
    @(negedge clk);
    address[k] = a; read[k] = !wr; write[k] = wr; writedata[k] = d; byteenable[k] = be;
    if (!wr) exp_q.push_back(in_rng(a) ? mdl[k][idx[5:0]] : 32'hDEADBEEF);
    stalls = 0;
    #1;
    while (waitrequest[k] && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 40) check_eq({tag, " timeout"}, 32'(waitrequest[k]), 32'd0);
    if (!wr) begin
      e = exp_q.pop_front();
      check_eq({tag, " data"}, readdata[k], e);
    end
    check_eq({tag, " stalls"}, stalls, n);
    @(posedge clk);
    #1;
    read[k] = 1'b0; write[k] = 1'b0;
    if (wr && in_rng(a)) begin
      w = mdl[k][idx[5:0]];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[k][idx[5:0]] = w;
    end
    lfsr_m[k] = lfsr_adv(lfsr_m[k]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; address[k] = '0; read[k] = 1'b0; write[k] = 1'b0;
      byteenable[k] = '0; writedata[k] = '0; lfsr_m[k] = 8'hA5;
      for (int j = 0; j < DEPTH; j++) mdl[k][j] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst waitrequest", 32'(waitrequest[k]), 32'd0);
      check_eq("rst readdata", readdata[k], 32'd0);
      check_eq("rst err", 32'(err[k]), 32'd0);
      check_eq("rst rd_count", rd_count[k], 32'd0);
      check_eq("rst wr_count", wr_count[k], 32'd0);
      check_eq("rst stall_count", stall_count[k], 32'd0);
    end

    // zero-wait: preload word0 then read it in the same cycle
    xfer(0, 1'b1, BASE, 32'h24020005, 4'hF, "w0 preload");
    xfer(0, 1'b0, BASE, 32'h0, 4'h0, "w0 read");
    check_eq("w0 rd_count", rd_count[0], 32'd1);
    check_eq("w0 stall_count", stall_count[0], 32'd0);
    check_eq("w0 err", 32'(err[0]), 32'd0);

    // three fixed wait states with partial byte enables
    xfer(1, 1'b1, BASE + 32'h10, 32'hAABBCCDD, 4'hF, "w3 preload");
    xfer(1, 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, "w3 be write");
    xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "w3 readback");
    check_eq("w3 literal", mdl[1][4], 32'hAA22CC44);
    check_eq("w3 stall_count", stall_count[1], 32'd9);
    check_eq("w3 wr_count", wr_count[1], 32'd2);
    check_eq("w3 rd_count", rd_count[1], 32'd1);

    // random waits: 20 writes then 20 back-to-back reads
    for (int i = 0; i < 20; i++)
      xfer(2, 1'b1, BASE + 32'(4 * i), 32'h10000000 + 32'(i) * 32'h00010203, 4'hF, "rnd write");
    for (int i = 0; i < 20; i++)
      xfer(2, 1'b0, BASE + 32'(4 * i), 32'h0, 4'h0, "rnd read");
    check_eq("rnd rd_count", rd_count[2], 32'd20);
    check_eq("rnd wr_count", wr_count[2], 32'd20);

    // out of range and misaligned reads
    do_reset(0);
    xfer(0, 1'b0, 32'h00000000, 32'h0, 4'h0, "oor read");
    check_eq("oor err", 32'(err[0]), 32'd1);
    xfer(0, 1'b0, BASE + 32'h2, 32'h0, 4'h0, "misaligned read");
    check_eq("oor rd_count", rd_count[0], 32'd2);

    // read and write together
    do_reset(1);
    @(negedge clk);
    address[1] = BASE + 32'h10; read[1] = 1'b1; write[1] = 1'b1;
    writedata[1] = 32'hFFFFFFFF; byteenable[1] = 4'hF;
    #1;
    check_eq("rw waitrequest", 32'(waitrequest[1]), 32'd0);
    check_eq("rw readdata", readdata[1], 32'd0);
    @(posedge clk);
    #1;
    read[1] = 1'b0; write[1] = 1'b0;
    check_eq("rw err", 32'(err[1]), 32'd1);
    check_eq("rw wr_count", wr_count[1], 32'd0);
    check_eq("rw rd_count", rd_count[1], 32'd0);
    xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "rw after");

    // read dropped while stalled
    do_reset(1);
    @(negedge clk);
    address[1] = BASE + 32'h10; read[1] = 1'b1;
    @(negedge clk);
    #1;
    check_eq("drop in stall", 32'(waitrequest[1]), 32'd1);
    read[1] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("drop err", 32'(err[1]), 32'd1);
    check_eq("drop rd_count", rd_count[1], 32'd0);
    check_eq("drop stall_count", stall_count[1], 32'd2);
    xfer(1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "drop after");

    // reset during a stalled write
    do_reset(2);
    @(negedge clk);
    address[2] = BASE; write[2] = 1'b1; writedata[2] = 32'h0BADF00D; byteenable[2] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0; write[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    lfsr_m[2] = 8'hA5;
    #1;
    check_eq("mrst err", 32'(err[2]), 32'd0);
    check_eq("mrst wr_count", wr_count[2], 32'd0);
    check_eq("mrst stall_count", stall_count[2], 32'd0);
    xfer(2, 1'b0, BASE, 32'h0, 4'h0, "mrst read");
    check_eq("mrst stalls after", stall_count[2], 32'd5);
    check_eq("mrst rd_count", rd_count[2], 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
